// File: rtl/alu_regfile_pkg.sv
// Shared constants and flag encoding for the ALU operand register file.
package alu_regfile_pkg;

   localparam int unsigned WIDTH    = 32;
   localparam int unsigned NREG     = 32;
   localparam int unsigned AW       = 5;
   localparam int unsigned ZERO_REG = 0;
   localparam int unsigned NFLAGS   = 3;

   // Bit positions inside the packed ALU flag vector
   typedef enum logic [1:0] {
      FLAG_Z = 2'd0,
      FLAG_V = 2'd1,
      FLAG_C = 2'd2
   } flag_idx_e;

   typedef logic [NFLAGS-1:0] flags_t;

   // Pack individual ALU flag bits into the shared flag vector layout
   function automatic flags_t pack_flags(input logic zero, input logic ovf, input logic cout);
      flags_t f;
      f         = '0;
      f[FLAG_Z] = zero;
      f[FLAG_V] = ovf;
      f[FLAG_C] = cout;
      return f;
   endfunction

endpackage

// File: rtl/alu_regfile_if.sv
// Operand read, write-back and flag bus between the ALU and its register file.
interface alu_regfile_if;
   import alu_regfile_pkg::*;

   logic [AW-1:0]    ra_addr;
   logic [AW-1:0]    rb_addr;
   logic [WIDTH-1:0] ra_data;
   logic [WIDTH-1:0] rb_data;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             flags_we;
   logic             zero_in;
   logic             ovf_in;
   logic             cout_in;
   logic             ovf_clr;
   logic             zero_flag;
   logic             ovf_flag;
   logic             cout_flag;
   logic             ovf_sticky;

   modport master (
      output ra_addr, rb_addr, wr_en, wr_addr, wr_data,
      output flags_we, zero_in, ovf_in, cout_in, ovf_clr,
      input  ra_data, rb_data, zero_flag, ovf_flag, cout_flag, ovf_sticky
   );

   modport slave (
      input  ra_addr, rb_addr, wr_en, wr_addr, wr_data,
      input  flags_we, zero_in, ovf_in, cout_in, ovf_clr,
      output ra_data, rb_data, zero_flag, ovf_flag, cout_flag, ovf_sticky
   );

endinterface

// File: rtl/alu_regfile_rdport.sv
// One combinational read port: register-0 masking plus same-cycle write bypass.
module alu_regfile_rdport
   import alu_regfile_pkg::*;
(
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_mem_data,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic [WIDTH-1:0] o_data
);

   logic w_is_zero;
   logic w_bypass;

   assign w_is_zero = (i_addr == AW'(ZERO_REG));
   assign w_bypass  = i_wr_en && (i_wr_addr == i_addr) && !w_is_zero;

   // Zero register wins, then in-flight write data, then stored value
   always_comb begin
      o_data = i_mem_data;
      if (w_is_zero) begin
         o_data = '0;
      end else if (w_bypass) begin
         o_data = i_wr_data;
      end
   end

endmodule

// File: rtl/alu_regfile.sv
// ALU operand register file: 2 bypassed read ports, 1 write port, flags and sticky overflow.
module alu_regfile
   import alu_regfile_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   alu_regfile_if.slave  bus
);

   logic [WIDTH-1:0] r_mem [NREG];
   flags_t           r_flags;
   logic             r_ovf_sticky;
   logic [WIDTH-1:0] w_ra_mem;
   logic [WIDTH-1:0] w_rb_mem;
   logic             w_wr_ok;

   assign w_wr_ok  = bus.wr_en && (bus.wr_addr != AW'(ZERO_REG));
   assign w_ra_mem = r_mem[bus.ra_addr];
   assign w_rb_mem = r_mem[bus.rb_addr];

   // Storage array; reset clears every entry and drops any concurrent write
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Flag capture and sticky overflow; a new overflow beats a clear
   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags      <= '0;
         r_ovf_sticky <= 1'b0;
      end else begin
         if (bus.flags_we) begin
            r_flags <= pack_flags(bus.zero_in, bus.ovf_in, bus.cout_in);
         end
         if (bus.flags_we && bus.ovf_in) begin
            r_ovf_sticky <= 1'b1;
         end else if (bus.ovf_clr) begin
            r_ovf_sticky <= 1'b0;
         end
      end
   end

   assign bus.zero_flag  = r_flags[FLAG_Z];
   assign bus.ovf_flag   = r_flags[FLAG_V];
   assign bus.cout_flag  = r_flags[FLAG_C];
   assign bus.ovf_sticky = r_ovf_sticky;

   alu_regfile_rdport u_rdport_a (
      .i_addr     (bus.ra_addr),
      .i_mem_data (w_ra_mem),
      .i_wr_en    (bus.wr_en),
      .i_wr_addr  (bus.wr_addr),
      .i_wr_data  (bus.wr_data),
      .o_data     (bus.ra_data)
   );

   alu_regfile_rdport u_rdport_b (
      .i_addr     (bus.rb_addr),
      .i_mem_data (w_rb_mem),
      .i_wr_en    (bus.wr_en),
      .i_wr_addr  (bus.wr_addr),
      .i_wr_data  (bus.wr_data),
      .o_data     (bus.rb_data)
   );

endmodule

// File: doc/alu_regfile.md
Name: alu_regfile

Overview:
- Register file that sources the ALU's two 32-bit operands (inA/inB) and accepts the ALU result plus zero/overflow/carry-out flags at write-back.
- Sits directly upstream of the ALU in the datapath. It also closes the loop from the ALU outputs.
- Provides 2 combinational read ports with write-through bypass and 1 synchronous write port.
- Holds a registered flag set and a sticky overflow bit.

Parameters:
- WIDTH, 32, data width of each register and of the ALU operands
- NREG, 32, number of architectural registers; register 0 is hardwired zero
- AW, 5, address width; must satisfy 2**AW == NREG

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- ra_addr  input  AW  read port A address; drives ALU inA
- rb_addr  input  AW  read port B address; drives ALU inB
- ra_data  output  WIDTH  read port A data (combinational)
- rb_data  output  WIDTH  read port B data (combinational)
- wr_en  input  1  write strobe for the ALU result
- wr_addr  input  AW  destination register
- wr_data  input  WIDTH  ALU Out
- flags_we  input  1  capture ALU flags this cycle
- zero_in  input  1  ALU zero
- ovf_in  input  1  ALU overflow
- cout_in  input  1  ALU CoutFinal
- ovf_clr  input  1  clear sticky overflow
- zero_flag  output  1  registered zero
- ovf_flag  output  1  registered overflow
- cout_flag  output  1  registered carry-out
- ovf_sticky  output  1  set on any captured overflow; held until cleared

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset (reset=1 at rising edge):
  - All NREG registers are cleared to 0.
  - zero_flag, ovf_flag, cout_flag and ovf_sticky go to 0.
  - Reset overrides wr_en, flags_we and ovf_clr in the same cycle.
  - Reset asserted mid-sequence discards any pending write.
- Write: on a rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. Writes to address 0 are ignored.
- Read: combinational, zero latency.
  - Address 0 always returns 0.
  - Otherwise the port returns reg[addr].
- Bypass: if wr_en=1, wr_addr!=0 and wr_addr==ra_addr, then ra_data = wr_data in the same cycle. Port B follows the identical rule. Both ports may bypass simultaneously when ra_addr==rb_addr==wr_addr.
- Flags:
  - On a rising edge with flags_we=1: zero_flag<=zero_in, ovf_flag<=ovf_in, cout_flag<=cout_in.
  - With flags_we=0 all three flags hold.
- Sticky overflow:
  - Set when flags_we=1 and ovf_in=1.
  - Cleared by ovf_clr=1.
  - Simultaneous set and clear in the same cycle: set wins, so ovf_sticky=1.
- No stall or handshake: a write and flag capture complete in one cycle. The write-to-read latency observed through the storage array is 1 cycle; the bypass makes it 0.
- Width rules: no arithmetic is performed here; data passes through unmodified at WIDTH bits.

Decomposition:
- Shared package holds:
  - WIDTH/NREG/AW defaults
  - ZERO_REG constant (0)
  - a flag-index enum (FLAG_Z=0, FLAG_V=1, FLAG_C=2), used by the ALU and this block for a packed 3-bit flag vector
- One sub-module is natural: alu_regfile_rdport, holding the address-0 masking and bypass mux, instantiated twice.
- The storage array and the flag/sticky logic stay in the top module.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every read returns 0x00000000; all four flag outputs are 0.
- Write 0xDEADBEEF to r5, next cycle ra_addr=5, rb_addr=5 -> both ports read 0xDEADBEEF. Write 0x12345678 to r0, then read r0 -> 0x00000000.
- Same cycle: wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, ra_addr=7 -> ra_data=0xA5A5A5A5 combinationally before the edge. Same stimulus with wr_addr=0, ra_addr=0 -> ra_data=0.
- flags_we=1 with zero_in=1, ovf_in=1, cout_in=0 -> after the edge Z=1, V=1, C=0, sticky=1. Next flags_we=1 with all inputs 0 -> V=0 but sticky stays 1. Then ovf_clr=1 -> sticky=0.
- Same cycle: ovf_clr=1, flags_we=1, ovf_in=1 -> sticky=1 (set wins).
- Write 0xFFFFFFFF to r9 and set sticky, then assert reset with wr_en=1, wr_addr=9, wr_data=0x1 -> after the edge r9=0 and sticky=0.
